// File: rtl/melody_tone_gen.sv
// Melody sequencer: walks a fixed 16-entry note ROM and drives a square-wave
// tone for each pitched step, with silent rests and an articulation gap.
module melody_tone_gen #(
    parameter int CLK_FREQ    = 50000000,
    parameter int UNIT_CYCLES = 6250000,
    parameter int GAP_CYCLES  = 625000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    output logic       tone_out,
    output logic       playing,
    output logic [3:0] step_idx,
    output logic       done
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_LOAD  | fetch ROM[step_idx], decode note/duration
    // S_PLAY  | tone (or silence for a rest) for dur units
    // S_GAP   | articulation silence, then advance step
    // S_DONE  | one-cycle done pulse before returning to idle
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE} state_t;

    localparam int HP_C4_RAW = CLK_FREQ / (2 * 262);
    localparam int HP_W      = ($clog2(HP_C4_RAW + 1) < 17) ? 17 : $clog2(HP_C4_RAW + 1);
    localparam int CNT_MAX   = (UNIT_CYCLES > GAP_CYCLES) ? UNIT_CYCLES : GAP_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    // Terminal counts (HP-1) for each pitch, resolved at elaboration.
    localparam logic [HP_W-1:0] HPL_C4 = HP_W'(CLK_FREQ / (2 * 262) - 1);
    localparam logic [HP_W-1:0] HPL_D4 = HP_W'(CLK_FREQ / (2 * 294) - 1);
    localparam logic [HP_W-1:0] HPL_E4 = HP_W'(CLK_FREQ / (2 * 330) - 1);
    localparam logic [HP_W-1:0] HPL_F4 = HP_W'(CLK_FREQ / (2 * 349) - 1);
    localparam logic [HP_W-1:0] HPL_G4 = HP_W'(CLK_FREQ / (2 * 392) - 1);
    localparam logic [HP_W-1:0] HPL_A4 = HP_W'(CLK_FREQ / (2 * 440) - 1);
    localparam logic [HP_W-1:0] HPL_B4 = HP_W'(CLK_FREQ / (2 * 494) - 1);
    localparam logic [HP_W-1:0] HPL_C5 = HP_W'(CLK_FREQ / (2 * 523) - 1);

    localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t          state;
    logic [HP_W-1:0] hp_cnt;
    logic [HP_W-1:0] hp_last;
    logic            pitched;
    logic [CNT_W-1:0] cyc_cnt;
    logic [3:0]      units_left;

    logic [6:0]      rom_word;
    logic [3:0]      rom_note;
    logic [2:0]      rom_dur;
    logic [HP_W-1:0] rom_hp_last;
    logic            rom_pitched;
    logic            rom_end;

    function automatic logic [6:0] rom_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    rom_entry = {4'd1, 3'd2};
            4'd1:    rom_entry = {4'd2, 3'd2};
            4'd2:    rom_entry = {4'd3, 3'd2};
            4'd3:    rom_entry = {4'd4, 3'd2};
            4'd4:    rom_entry = {4'd5, 3'd2};
            4'd5:    rom_entry = {4'd6, 3'd2};
            4'd6:    rom_entry = {4'd7, 3'd2};
            4'd7:    rom_entry = {4'd8, 3'd2};
            4'd8:    rom_entry = {4'd0, 3'd1};
            default: rom_entry = {4'd15, 3'd0};
        endcase
    endfunction

    always_comb begin
        rom_word    = rom_entry(step_idx);
        rom_note    = rom_word[6:3];
        rom_dur     = rom_word[2:0];
        rom_end     = (rom_note == 4'd15);
        rom_pitched = 1'b1;
        rom_hp_last = '0;
        case (rom_note)
            4'd1:    rom_hp_last = HPL_C4;
            4'd2:    rom_hp_last = HPL_D4;
            4'd3:    rom_hp_last = HPL_E4;
            4'd4:    rom_hp_last = HPL_F4;
            4'd5:    rom_hp_last = HPL_G4;
            4'd6:    rom_hp_last = HPL_A4;
            4'd7:    rom_hp_last = HPL_B4;
            4'd8:    rom_hp_last = HPL_C5;
            default: rom_pitched = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tone_out   <= 1'b0;
            playing    <= 1'b0;
            step_idx   <= 4'd0;
            done       <= 1'b0;
            hp_cnt     <= '0;
            hp_last    <= '0;
            pitched    <= 1'b0;
            cyc_cnt    <= '0;
            units_left <= 4'd0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state      <= S_IDLE;
                tone_out   <= 1'b0;
                playing    <= 1'b0;
                step_idx   <= 4'd0;
                hp_cnt     <= '0;
                cyc_cnt    <= '0;
                units_left <= 4'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state    <= S_LOAD;
                            playing  <= 1'b1;
                            step_idx <= 4'd0;
                        end
                    end
                    S_LOAD: begin
                        if (rom_end) begin
                            if (loop_en) begin
                                step_idx <= 4'd0;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            state      <= S_PLAY;
                            hp_cnt     <= '0;
                            cyc_cnt    <= '0;
                            hp_last    <= rom_hp_last;
                            pitched    <= rom_pitched;
                            units_left <= (rom_dur == 3'd0) ? 4'd8 : {1'b0, rom_dur};
                            tone_out   <= 1'b0;
                        end
                    end
                    S_PLAY: begin
                        if (pitched) begin
                            if (hp_cnt == hp_last) begin
                                hp_cnt   <= '0;
                                tone_out <= ~tone_out;
                            end else begin
                                hp_cnt <= hp_cnt + 1'b1;
                            end
                        end
                        // End of the last unit overrides any toggle landing on the same edge.
                        if (cyc_cnt == UNIT_LAST) begin
                            cyc_cnt    <= '0;
                            units_left <= units_left - 4'd1;
                            if (units_left == 4'd1) begin
                                state    <= S_GAP;
                                tone_out <= 1'b0;
                            end
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (cyc_cnt == GAP_LAST) begin
                            cyc_cnt  <= '0;
                            step_idx <= step_idx + 4'd1;
                            state    <= S_LOAD;
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state    <= S_IDLE;
                        playing  <= 1'b0;
                        step_idx <= 4'd0;
                    end
                    default: begin
                        state    <= S_IDLE;
                        tone_out <= 1'b0;
                        playing  <= 1'b0;
                        step_idx <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_tone_gen.sv
// Directed bench for melody_tone_gen with scaled-down timing
// (1 MHz clock, 1000-cycle units, 100-cycle gaps).
module tb_melody_tone_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic       tone_out;
    logic       playing;
    logic [3:0] step_idx;
    logic       done;

    int errors = 0;
    int checks = 0;
    int cur = 0;
    int done_cnt = 0;
    int done_before;

    melody_tone_gen #(
        .CLK_FREQ(1000000),
        .UNIT_CYCLES(1000),
        .GAP_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .loop_en(loop_en),
        .tone_out(tone_out),
        .playing(playing),
        .step_idx(step_idx),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic goto(input int target);
        while (cur < target) step_edge();
    endtask

    // Pulse start for one edge; the cycle after that edge is cycle 0 (LOAD).
    task automatic kick();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cur = 0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; stop = 1'b0; loop_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_tone", tone_out, 0);
        check("rst_playing", playing, 0);
        check("rst_step", step_idx, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_playing", playing, 1);
        check("rel_step", step_idx, 0);
        start = 1'b0; stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check("rel_stop_idle", playing, 0);

        // Full non-looped melody with a stray start during step 0 PLAY.
        kick();
        check("c0_playing", playing, 1);
        check("c0_step", step_idx, 0);
        check("c0_tone", tone_out, 0);
        goto(1000); start = 1'b1; step_edge(); start = 1'b0;
        goto(1908); check("c4_pre_toggle", tone_out, 0);
        goto(1909); check("c4_toggle", tone_out, 1);
        goto(2000); check("c4_last_play", tone_out, 1);
        goto(2001); check("gap_tone", tone_out, 0);
        check("gap_step", step_idx, 0);
        goto(2100); check("gap_end_step", step_idx, 0);
        goto(2101); check("step1_idx", step_idx, 1);
        check("step1_tone", tone_out, 0);
        goto(3801); check("d4_pre_toggle", tone_out, 0);
        goto(3802); check("d4_toggle", tone_out, 1);
        goto(15663); check("c5_pre_toggle", tone_out, 0);
        goto(15664); check("c5_toggle", tone_out, 1);
        goto(16619); check("c5_hold", tone_out, 1);
        goto(16620); check("c5_toggle2", tone_out, 0);
        goto(16809); check("rest_step", step_idx, 8);
        check("rest_tone_a", tone_out, 0);
        goto(17300); check("rest_tone_b", tone_out, 0);
        goto(17808); check("rest_tone_c", tone_out, 0);
        check("rest_playing", playing, 1);
        goto(17909); check("end_step", step_idx, 9);
        check("end_done", done, 0);
        goto(17910); check("done_pulse", done, 1);
        check("done_playing", playing, 1);
        goto(17911); check("post_done", done, 0);
        check("post_playing", playing, 0);
        check("post_step", step_idx, 0);
        goto(17920); check("done_count", done_cnt, 1);

        // Looping for three full passes.
        loop_en = 1'b1;
        done_before = done_cnt;
        kick();
        goto(17909); check("loop_end_step", step_idx, 9);
        goto(17910); check("loop_restart_step", step_idx, 0);
        check("loop_restart_play", playing, 1);
        goto(19818); check("loop_c4_pre", tone_out, 0);
        goto(19819); check("loop_c4_toggle", tone_out, 1);
        goto(53730); check("loop3_step", step_idx, 0);
        check("loop3_playing", playing, 1);
        check("loop_no_done", done_cnt, done_before);
        stop = 1'b1; step_edge(); stop = 1'b0;
        check("loop_stop", playing, 0);

        // Stop in the middle of step 3.
        loop_en = 1'b0;
        done_before = done_cnt;
        kick();
        goto(6303); check("s3_step", step_idx, 3);
        goto(6804); check("s3_playing", playing, 1);
        stop = 1'b1; step_edge(); stop = 1'b0;
        check("stop_tone", tone_out, 0);
        check("stop_playing", playing, 0);
        check("stop_step", step_idx, 0);
        goto(6830); check("stop_no_done", done_cnt, done_before);
        check("stop_idle_hold", playing, 0);
        kick();
        check("restart_step", step_idx, 0);
        goto(1908); check("restart_c4_pre", tone_out, 0);
        goto(1909); check("restart_c4_toggle", tone_out, 1);
        stop = 1'b1; step_edge(); stop = 1'b0;

        // start and stop together while idle.
        start = 1'b1; stop = 1'b1;
        step_edge();
        check("both_playing", playing, 0);
        start = 1'b0; stop = 1'b0;
        step_edge(); step_edge();
        check("both_stay_idle", playing, 0);
        check("both_step", step_idx, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/melody_tone_gen.md
Name: melody_tone_gen

Overview:
Sequencer and square-wave tone generator for the music-buzz challenge. It steps through a fixed 16-entry melody ROM and outputs a pitched square wave, with silences for rests and gaps. tone_out feeds the downstream buzzer output stage, which passes it directly to the piezo pin. Playback is controlled by start/stop pulses from debounced board buttons.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz; used to compute the pitch half-periods.
UNIT_CYCLES, 6250000, clock cycles per duration unit (125 ms at 50 MHz).
GAP_CYCLES, 625000, silent cycles inserted after every played step (articulation gap).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  level sampled each cycle; begins playback from step 0 when idle
stop  input  1  aborts playback and returns to idle
loop_en  input  1  1 = restart at step 0 on END; 0 = finish and pulse done
tone_out  output  1  square-wave tone to the buzzer stage
playing  output  1  high whenever the block is not idle
step_idx  output  4  current melody ROM index
done  output  1  one-cycle pulse when a non-looped melody completes

Behaviour:
- Reset: clk and rst_n are the only clock and reset. rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, tone_out=0, playing=0, step_idx=0, done=0, and all counters are 0. Reset asserted mid-note aborts immediately, with no done pulse.
- ROM entry format: {note[3:0], dur[2:0]}.
  - note codes: 0 = rest; 1..8 = C4, D4, E4, F4, G4, A4, B4, C5 (262, 294, 330, 349, 392, 440, 494, 523 Hz); 15 = END; 9..14 are treated as rest.
  - dur: 1..7 units; dur=0 is treated as 8 units.
- Half-period: HP = CLK_FREQ/(2*f), integer floor, computed at elaboration. The counter is 17-bit minimum and must hold HP(C4) at 50 MHz = 95419.
- Melody contents:
  - steps 0..7: notes 1..8, dur=2
  - step 8: rest, dur=1
  - steps 9..15: END
- State machine: IDLE, LOAD, PLAY, GAP, DONE.
  - IDLE: when start=1 and stop=0, go to LOAD with step_idx=0.
  - LOAD (1 cycle): read ROM[step_idx].
    - END with loop_en=1: step_idx<=0 and stay in LOAD.
    - END with loop_en=0: go to DONE.
    - Otherwise: go to PLAY, clear the half-period and unit counters, and set tone_out=0.
  - PLAY: lasts exactly dur*UNIT_CYCLES cycles, then goes to GAP.
    - For a pitched note, the half-period counter runs 0..HP-1; at HP-1 it wraps and tone_out toggles. The first toggle is HP cycles after entering PLAY.
    - For a rest, tone_out is held at 0.
  - GAP: tone_out=0 for GAP_CYCLES cycles, then step_idx increments (4-bit, 15 wraps to 0) and the state goes to LOAD.
  - DONE (1 cycle): done=1, then go to IDLE with step_idx=0.
- Per-step cost is 1 + dur*UNIT_CYCLES + GAP_CYCLES cycles.
- Outputs:
  - playing = (state != IDLE), registered.
  - tone_out is registered and glitch-free, and is 0 in IDLE, LOAD, GAP and DONE.
- stop has priority in every state. stop=1 at an edge forces IDLE, tone_out=0, step_idx=0, with no done pulse. start and stop high in the same cycle: stop wins.
- start while not IDLE is ignored; it does not restart playback.
- loop_en is sampled only at LOAD on END, so it may change mid-melody.

Test Plan:
1. Reset: hold rst_n=0 for 5 cycles with start=1 -> tone_out=0, playing=0, step_idx=0, done=0. Release -> playback begins via LOAD.
2. Timing (CLK_FREQ=1000000, UNIT_CYCLES=1000, GAP_CYCLES=100): start pulse -> LOAD at cycle 0, PLAY cycles 1..2000, tone_out toggling every 1908 cycles. Then tone_out=0 for cycles 2001..2100 and step_idx=1 at cycle 2101.
3. Full play, loop_en=0, same parameters -> rest step 8 keeps tone_out=0 for 1000 cycles. done is high only at cycle 17910, then playing=0 and step_idx=0.
4. loop_en=1 -> after step 8's gap, END causes step_idx=0 and C4 restarts. done never asserts over 3 loops.
5. stop at cycle 500 of step 3 -> next edge: tone_out=0, playing=0, step_idx=0, no done. A later start restarts at step 0 with C4.
6. start and stop both high in IDLE -> block stays IDLE. start pulsed during PLAY -> step_idx and timing are unaffected.
